// File: rtl/usb_uart_stream_fifo.sv
// Valid/ready byte-stream adapter for the USB CDC bridge UART port.
// TX and RX FIFOs, with a sequencer that issues one bridge transaction at a time.
module usb_uart_stream_fifo #(
  parameter int TX_AW      = 4,
  parameter int RX_AW      = 4,
  parameter int RD_TIMEOUT = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic [TX_AW:0]   tx_level,
  output logic [RX_AW:0]   rx_level,
  output logic             uart_we,
  output logic             uart_re,
  output logic [7:0]       uart_di,
  input  logic [7:0]       uart_do,
  input  logic             uart_wait,
  input  logic             uart_ready
);

  localparam int CW = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
  localparam logic [CW-1:0]  CNT_LAST   = CW'(RD_TIMEOUT - 1);
  localparam logic [CW-1:0]  CNT_ONE    = CW'(1);
  localparam logic [CW-1:0]  CNT_ZERO   = CW'(0);
  localparam logic [TX_AW:0] TX_PTR_ONE = (TX_AW + 1)'(1);
  localparam logic [RX_AW:0] RX_PTR_ONE = (RX_AW + 1)'(1);
  localparam logic           PRIO_TX    = 1'b0;
  localparam logic           PRIO_RX    = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_ACK  = 3'd1,
    ST_WR_BUSY = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_GUARD   = 3'd4
  } state_t;

  logic [7:0]    tx_mem_r [0:(1 << TX_AW) - 1];
  logic [7:0]    rx_mem_r [0:(1 << RX_AW) - 1];
  logic [TX_AW:0] tx_wptr_r, tx_rptr_r;
  logic [RX_AW:0] rx_wptr_r, rx_rptr_r;
  logic tx_full_s, tx_empty_s, tx_push_s, tx_pop_s;
  logic rx_full_s, rx_empty_s, rx_push_s, rx_pop_s;

  state_t        state_r, state_s;
  logic          prio_r, prio_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic          uart_we_r, uart_re_r, we_s, re_s;
  logic [7:0]    uart_di_r, di_s;

  assign tx_full_s  = (tx_wptr_r[TX_AW] != tx_rptr_r[TX_AW]) &&
                      (tx_wptr_r[TX_AW-1:0] == tx_rptr_r[TX_AW-1:0]);
  assign tx_empty_s = (tx_wptr_r == tx_rptr_r);
  assign rx_full_s  = (rx_wptr_r[RX_AW] != rx_rptr_r[RX_AW]) &&
                      (rx_wptr_r[RX_AW-1:0] == rx_rptr_r[RX_AW-1:0]);
  assign rx_empty_s = (rx_wptr_r == rx_rptr_r);

  assign tx_ready  = ~tx_full_s;
  assign tx_push_s = tx_valid & ~tx_full_s;
  assign rx_valid  = ~rx_empty_s;
  assign rx_pop_s  = rx_ready & ~rx_empty_s;
  assign rx_data   = rx_mem_r[rx_rptr_r[RX_AW-1:0]];
  assign tx_level  = tx_wptr_r - tx_rptr_r;
  assign rx_level  = rx_wptr_r - rx_rptr_r;

  assign uart_we = uart_we_r;
  assign uart_re = uart_re_r;
  assign uart_di = uart_di_r;

  // FIFO storage; contents are meaningless once the pointers are reset
  always_ff @(posedge clk) begin
    if (tx_push_s) begin
      tx_mem_r[tx_wptr_r[TX_AW-1:0]] <= tx_data;
    end
    if (rx_push_s) begin
      rx_mem_r[rx_wptr_r[RX_AW-1:0]] <= uart_do;
    end
  end

  // FIFO pointers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_wptr_r <= '0;
      tx_rptr_r <= '0;
      rx_wptr_r <= '0;
      rx_rptr_r <= '0;
    end else begin
      if (tx_push_s) tx_wptr_r <= tx_wptr_r + TX_PTR_ONE;
      if (tx_pop_s)  tx_rptr_r <= tx_rptr_r + TX_PTR_ONE;
      if (rx_push_s) rx_wptr_r <= rx_wptr_r + RX_PTR_ONE;
      if (rx_pop_s)  rx_rptr_r <= rx_rptr_r + RX_PTR_ONE;
    end
  end

  // Sequencer next state and next bridge outputs
  always_comb begin
    state_s   = state_r;
    prio_s    = prio_r;
    cnt_s     = cnt_r;
    we_s      = 1'b0;
    re_s      = 1'b0;
    di_s      = uart_di_r;
    tx_pop_s  = 1'b0;
    rx_push_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // priority only flips when both sides actually contend
        if (!tx_empty_s && (rx_full_s || prio_r == PRIO_TX)) begin
          tx_pop_s = 1'b1;
          di_s     = tx_mem_r[tx_rptr_r[TX_AW-1:0]];
          we_s     = 1'b1;
          state_s  = ST_WR_ACK;
          if (!rx_full_s) prio_s = PRIO_RX;
          else            prio_s = prio_r;
        end else if (!rx_full_s) begin
          re_s    = 1'b1;
          cnt_s   = CNT_ZERO;
          state_s = ST_RD_WAIT;
          if (!tx_empty_s) prio_s = PRIO_TX;
          else             prio_s = prio_r;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WR_ACK: begin
        if (uart_wait) state_s = ST_WR_BUSY;
        else           state_s = ST_WR_ACK;
      end
      ST_WR_BUSY: begin
        if (!uart_wait) state_s = ST_GUARD;
        else            state_s = ST_WR_BUSY;
      end
      ST_RD_WAIT: begin
        // space was reserved at issue time, so this push cannot overflow
        if (uart_ready) begin
          rx_push_s = 1'b1;
          state_s   = ST_GUARD;
        end else if (cnt_r == CNT_LAST) begin
          state_s = ST_GUARD;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_GUARD: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Sequencer state and registered bridge outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      prio_r    <= PRIO_TX;
      cnt_r     <= CNT_ZERO;
      uart_we_r <= 1'b0;
      uart_re_r <= 1'b0;
      uart_di_r <= 8'h00;
    end else begin
      state_r   <= state_s;
      prio_r    <= prio_s;
      cnt_r     <= cnt_s;
      uart_we_r <= we_s;
      uart_re_r <= re_s;
      uart_di_r <= di_s;
    end
  end

endmodule

// File: tb/tb_usb_uart_stream_fifo.sv
// Directed bench for usb_uart_stream_fifo with a reactive bridge model.
module tb_usb_uart_stream_fifo;

  logic       clk, reset;
  logic [7:0] tx_data, rx_data, uart_di, uart_do;
  logic       tx_valid, tx_ready, rx_valid, rx_ready;
  logic [4:0] tx_level, rx_level;
  logic       uart_we, uart_re, uart_wait, uart_ready;

  usb_uart_stream_fifo #(.TX_AW(4), .RX_AW(4), .RD_TIMEOUT(6)) dut (
    .clk(clk), .reset(reset),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_level(tx_level), .rx_level(rx_level),
    .uart_we(uart_we), .uart_re(uart_re), .uart_di(uart_di),
    .uart_do(uart_do), .uart_wait(uart_wait), .uart_ready(uart_ready)
  );

  typedef struct {
    logic [7:0] data;
    logic       valid;
    logic       exp_ready;
    logic [4:0] exp_level;
  } tvec_t;

  tvec_t      tbl [18];
  int         n_cmp, n_fail;
  int         cyc, rd_cnt, busy, viol, di_viol;
  logic       stall, wr_open, prev_we, prev_re;
  logic [7:0] cur_wr;
  logic [7:0] wr_log [$];
  logic [7:0] txn_log [$];
  logic [7:0] host_q [$];
  int         re_times [$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  // Bridge model: acts on the falling edge, drives inputs for the next rising edge
  initial begin
    cyc = 0; rd_cnt = 0; busy = 0; viol = 0; di_viol = 0;
    wr_open = 1'b0; prev_we = 1'b0; prev_re = 1'b0; cur_wr = 8'h00;
    uart_wait = 1'b0; uart_ready = 1'b0; uart_do = 8'h00;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        uart_wait = 1'b0; uart_ready = 1'b0; uart_do = 8'h00;
        rd_cnt = 0; busy = 0; wr_open = 1'b0;
      end else begin
        if (uart_we && uart_re) viol++;
        if ((uart_we && prev_we) || (uart_re && prev_re)) viol++;
        if (wr_open && uart_di !== cur_wr) di_viol++;
        uart_ready = 1'b0;
        if (uart_we) begin
          wr_log.push_back(uart_di);
          txn_log.push_back(8'h54);
          cur_wr = uart_di; wr_open = 1'b1; uart_wait = 1'b1; busy = 2;
        end else if (uart_wait && !stall) begin
          if (busy > 1) busy--;
          else begin uart_wait = 1'b0; wr_open = 1'b0; end
        end
        if (uart_re) begin
          txn_log.push_back(8'h52);
          re_times.push_back(cyc);
          if (host_q.size() > 0) rd_cnt = 3;
        end else if (rd_cnt > 0) begin
          rd_cnt--;
          if (rd_cnt == 0) begin
            uart_ready = 1'b1;
            uart_do = host_q.pop_front();
          end
        end
      end
      prev_we = uart_we; prev_re = uart_re;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b0; stall = 1'b0;
    tick(); tick();
    wr_log.delete(); txn_log.delete(); host_q.delete(); re_times.delete();
    viol = 0; di_viol = 0;
  endtask

  task automatic release_reset();
    reset = 1'b1;
  endtask

  task automatic push(input logic [7:0] b);
    tx_data = b; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic pop();
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
  endtask

  // Contention after a quiet poll: transactions must go T,R,T,R,T,R
  task automatic arb_run();
    for (int i = 0; i < 20 && !uart_re; i++) tick();
    check("arb_first_poll", {31'd0, uart_re}, 32'd1);
    tick();
    host_q.push_back(8'hC1); host_q.push_back(8'hC2); host_q.push_back(8'hC3);
    txn_log.delete(); wr_log.delete();
    push(8'h11); push(8'h22); push(8'h33);
    for (int i = 0; i < 200 && !(wr_log.size() == 3 && rx_level == 5'd3); i++) tick();
    check("arb_rx_level", {27'd0, rx_level}, 32'd3);
    check("arb_txn_count", {31'd0, txn_log.size() >= 6}, 32'd1);
    for (int i = 0; i < 6 && i < txn_log.size(); i++)
      check($sformatf("arb_order%0d", i), {24'd0, txn_log[i]}, (i % 2 == 0) ? 32'h54 : 32'h52);
    for (int i = 0; i < 3 && i < wr_log.size(); i++)
      check($sformatf("arb_wr%0d", i), {24'd0, wr_log[i]}, 32'h11 * (i + 1));
    for (int i = 0; i < 3; i++) begin
      check($sformatf("arb_rd%0d", i), {24'd0, rx_data}, 32'hC1 + i);
      pop();
    end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    for (int i = 0; i < 16; i++)
      tbl[i] = '{data: 8'hF0 + 8'(i), valid: 1'b1, exp_ready: 1'b1, exp_level: 5'(i + 1)};
    tbl[16] = '{data: 8'hFF, valid: 1'b1, exp_ready: 1'b0, exp_level: 5'd16};
    tbl[17] = '{data: 8'h00, valid: 1'b0, exp_ready: 1'b0, exp_level: 5'd16};

    // reset values
    do_reset();
    check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_levels", {22'd0, tx_level, rx_level}, 32'd0);
    check("rst_bridge", {22'd0, uart_we, uart_re, uart_di}, 32'd0);

    // write path
    release_reset();
    push(8'h41); push(8'h42); push(8'h43);
    for (int i = 0; i < 200 && !(wr_log.size() == 3 && tx_level == 5'd0); i++) tick();
    check("wr_count", wr_log.size(), 32'd3);
    for (int i = 0; i < 3 && i < wr_log.size(); i++)
      check($sformatf("wr_byte%0d", i), {24'd0, wr_log[i]}, 32'h41 + i);
    check("wr_tx_level", {27'd0, tx_level}, 32'd0);
    check("wr_protocol", viol, 32'd0);
    check("wr_di_stable", di_viol, 32'd0);

    // read path
    do_reset();
    host_q.push_back(8'h5A); host_q.push_back(8'hA5);
    release_reset();
    for (int i = 0; i < 100 && rx_level != 5'd2; i++) tick();
    check("rd_level", {27'd0, rx_level}, 32'd2);
    check("rd_valid", {31'd0, rx_valid}, 32'd1);
    check("rd_head0", {24'd0, rx_data}, 32'h5A);
    check("rd_spacing", (re_times.size() >= 2) ? re_times[1] - re_times[0] : 0, 32'd6);
    pop();
    check("rd_head1", {24'd0, rx_data}, 32'hA5);
    check("rd_level1", {27'd0, rx_level}, 32'd1);
    pop();
    check("rd_empty", {26'd0, rx_valid, rx_level}, 32'd0);

    // timeout and retry
    do_reset();
    release_reset();
    begin
      int rv_seen;
      rv_seen = 0;
      for (int i = 0; i < 40; i++) begin
        tick();
        if (rx_valid) rv_seen++;
      end
      check("to_rx_valid", rv_seen, 32'd0);
    end
    check("to_poll_count", {31'd0, re_times.size() >= 4}, 32'd1);
    for (int i = 1; i < re_times.size(); i++)
      check($sformatf("to_spacing%0d", i), re_times[i] - re_times[i-1], 32'd8);
    check("to_protocol", viol, 32'd0);

    // arbitration
    do_reset();
    release_reset();
    arb_run();

    // TX full boundary with the bridge stalling
    do_reset();
    release_reset();
    stall = 1'b1;
    push(8'hE0);
    for (int i = 0; i < 30 && !uart_wait; i++) tick();
    check("full_stalled", {31'd0, uart_wait}, 32'd1);
    for (int i = 0; i < 18; i++) begin
      tx_data = tbl[i].data; tx_valid = tbl[i].valid;
      check($sformatf("full_ready%0d", i), {31'd0, tx_ready}, {31'd0, tbl[i].exp_ready});
      tick();
      check($sformatf("full_level%0d", i), {27'd0, tx_level}, {27'd0, tbl[i].exp_level});
    end
    tx_valid = 1'b0;
    check("full_di_held", {24'd0, uart_di}, 32'hE0);
    stall = 1'b0;
    for (int i = 0; i < 600 && !(wr_log.size() == 17 && tx_level == 5'd0); i++) tick();
    check("full_drain", wr_log.size(), 32'd17);
    for (int i = 1; i < 17 && i < wr_log.size(); i++)
      check($sformatf("full_wr%0d", i), {24'd0, wr_log[i]}, 32'hEF + i);
    check("full_di_stable", di_viol, 32'd0);

    // RX full: no polling until a pop frees a slot
    do_reset();
    for (int i = 0; i < 17; i++) host_q.push_back(8'h80 + 8'(i));
    release_reset();
    for (int i = 0; i < 400 && rx_level != 5'd16; i++) tick();
    check("rxf_level", {27'd0, rx_level}, 32'd16);
    check("rxf_head", {24'd0, rx_data}, 32'h80);
    re_times.delete();
    for (int i = 0; i < 30; i++) tick();
    check("rxf_no_poll", re_times.size(), 32'd0);
    pop();
    check("rxf_after_pop", {19'd0, rx_level, rx_data}, {19'd0, 5'd15, 8'h81});
    for (int i = 0; i < 40 && rx_level != 5'd16; i++) tick();
    check("rxf_refill", {27'd0, rx_level}, 32'd16);
    check("rxf_host_drained", host_q.size(), 32'd0);

    // async reset during WR_BUSY
    do_reset();
    release_reset();
    stall = 1'b1;
    push(8'h77);
    for (int i = 0; i < 30 && !uart_wait; i++) tick();
    push(8'h78);
    tick();
    check("ar_pre_di", {24'd0, uart_di}, 32'h77);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("ar_bridge", {22'd0, uart_we, uart_re, uart_di}, 32'd0);
    check("ar_levels", {22'd0, tx_level, rx_level}, 32'd0);
    check("ar_flags", {30'd0, tx_ready, rx_valid}, 32'd2);
    do_reset();
    release_reset();
    arb_run();
    check("final_protocol", viol, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/usb_uart_stream_fifo.md
Name: usb_uart_stream_fifo

Overview:
- Buffered stream adapter on the UART-side port of the USB CDC endpoint bridge. Connects directly to the bridge's uart_we/uart_re/uart_di/uart_do/uart_wait/uart_ready.
- Presents valid/ready byte streams to user logic, with a TX FIFO toward the host and an RX FIFO from the host.
- Sequences single-byte bridge transactions, never overlapping them, and polls the bridge for host data whenever the RX FIFO has room.

Parameters:
- TX_AW, 4, log2 of TX FIFO depth (16 entries).
- RX_AW, 4, log2 of RX FIFO depth (16 entries).
- RD_TIMEOUT, 6, cycles waited for uart_ready after a read poll before the poll is abandoned.

Ports:
- clk  in  1  single clock for the block and the bridge.
- reset  in  1  asynchronous, active-low reset.
- tx_data  in  8  byte to send to host.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  TX FIFO not full; a byte is accepted when tx_valid && tx_ready.
- rx_data  out  8  head of RX FIFO (first-word fall-through).
- rx_valid  out  1  RX FIFO not empty.
- rx_ready  in  1  consumer pops when rx_valid && rx_ready.
- tx_level  out  TX_AW+1  TX FIFO occupancy.
- rx_level  out  RX_AW+1  RX FIFO occupancy.
- uart_we  out  1  one-cycle write strobe to bridge.
- uart_re  out  1  one-cycle read-poll strobe to bridge.
- uart_di  out  8  write byte to bridge; held stable for the whole write transaction.
- uart_do  in  8  read byte from bridge; valid with uart_ready.
- uart_wait  in  1  bridge write in progress.
- uart_ready  in  1  one-cycle pulse: uart_do holds a host byte.

Behaviour:
- Reset (reset=0, async): both FIFOs empty, tx_ready=1, rx_valid=0, levels=0, uart_we=0, uart_re=0, uart_di=0, FSM=IDLE, priority=TX.
- All bridge-side outputs are registered.
- uart_we and uart_re are never both 1, and each is high for exactly one cycle per transaction.
- FIFOs: circular buffers with AW+1-bit pointers. Full when the MSBs differ and the remaining bits are equal.
  - Simultaneous push and pop is legal, including when full on the pop side or empty on the push side; the level is unchanged.
  - Pointers wrap modulo 2^(AW+1).
- FSM states:
  - IDLE: candidates are TX (TX FIFO not empty) and RX (rx_level < 2^RX_AW).
    - If both are candidates, the one named by the priority bit wins; the priority bit then flips to the other side.
    - TX win: pop TX head into uart_di, set uart_we=1, go WR_ACK.
    - RX win: set uart_re=1, clear the timeout counter, go RD_WAIT.
    - Neither candidate: stay in IDLE.
  - WR_ACK: uart_we=0; wait for uart_wait=1, then go WR_BUSY.
  - WR_BUSY: wait for uart_wait=0, then go GUARD. uart_di is unchanged throughout.
  - RD_WAIT: uart_re=0.
    - On uart_ready=1: push uart_do into the RX FIFO and go GUARD.
    - Else, if the counter has reached RD_TIMEOUT-1: go GUARD, no push. This means the bridge had no host data.
    - Else: increment the counter.
  - GUARD: one cycle so the bridge can return to its idle state, then go IDLE.
- Bridge timing contract: uart_ready arrives 3 cycles after uart_re deasserts when data exists. RD_TIMEOUT must be ≥4.
- RX space is reserved before polling. A uart_ready therefore never meets a full RX FIFO, and no byte is dropped.
- A uart_ready received outside RD_WAIT is ignored.
- Minimum issue spacing:
  - write: IDLE→WR_ACK→(≥1)→WR_BUSY→(≥1)→GUARD→IDLE.
  - read: 1 + 4 + 1 cycles on success.
- Reset mid-transaction discards the FIFO contents and the holding byte. The bridge shares this reset.

Test Plan:
- Write path: push 0x41, 0x42, 0x43 with rx_ready=0 and no host data. Required: three uart_we pulses in order; uart_di=0x41/0x42/0x43, each stable from the pulse until uart_wait falls; no overlap with uart_re; tx_level returns to 0.
- Read path: bridge model returns 0x5A then 0xA5 on polls. Required: each byte appears on rx_data in order with rx_valid=1; rx_level=2 while rx_ready=0; each uart_ready arrives exactly 3 cycles after its uart_re.
- Timeout and retry: no host data for 40 cycles. Required: repeated uart_re polls, one per 1+RD_TIMEOUT+1=8 cycles, with no push and rx_valid=0.
- Arbitration: TX FIFO non-empty and host data pending together. Required: transactions alternate TX, RX, TX, RX; the first is TX because priority=TX after reset.
- Full boundaries:
  - Push 17 bytes with the bridge stalling uart_wait high. Required: tx_ready=0 at level 16.
  - Fill the RX FIFO to 16. Required: no further uart_re until one pop.
- Async reset during WR_BUSY. Required: all outputs return to reset values immediately; levels=0; after reset is released, IDLE with priority=TX.
